// File: rtl/bitser_cpu_core_pkg.sv
// Shared types for the bit-serial accumulator core: opcodes, FSM states and
// instruction field positions.
package bitser_cpu_core_pkg;

    localparam int OPC_W      = 4;
    localparam int R_TYPE_BIT = 3;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'd0,
        OP_ADD   = 3'd1,
        OP_SUB   = 3'd2,
        OP_AND   = 3'd3,
        OP_OR    = 3'd4,
        OP_XOR   = 3'd5,
        OP_STORE = 3'd6,
        OP_OUT   = 3'd7
    } opcode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_e;

    function automatic logic is_alu_op(input opcode_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/bitser_cpu_core_alu_bit_p.sv
// One-bit ALU slice with its carry flop; the carry is preset at instruction
// accept and advances only while a serial ALU op runs.
module alu_bit_p
    import bitser_cpu_core_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    preset_i,
    input  logic    cin_i,
    input  logic    en_i,
    input  opcode_e op_i,
    input  logic    a_i,
    input  logic    b_i,
    output logic    res_o,
    output logic    cout_o
);

    logic carry_q;
    logic b_eff;

    // Subtraction is a + ~b + 1; the +1 arrives through the preset carry.
    assign b_eff = (op_i == OP_SUB) ? ~b_i : b_i;

    always_comb begin
        res_o  = b_i;
        cout_o = carry_q;
        unique case (op_i)
            OP_ADD, OP_SUB: begin
                res_o  = a_i ^ b_eff ^ carry_q;
                cout_o = (a_i & b_eff) | (carry_q & (a_i ^ b_eff));
            end
            OP_AND:  res_o = a_i & b_i;
            OP_OR:   res_o = a_i | b_i;
            OP_XOR:  res_o = a_i ^ b_i;
            default: res_o = b_i;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else if (preset_i) begin
            carry_q <= cin_i;
        end else if (en_i) begin
            carry_q <= cout_o;
        end
    end

endmodule

// File: rtl/bitser_cpu_core.sv
// Bit-serial accumulator CPU: valid/ready instruction intake, LSB-first ALU
// ops over WIDTH cycles, small register file, zero/carry flags, OUT strobe.
module bitser_cpu_core
    import bitser_cpu_core_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 4,
    localparam int IW    = WIDTH + 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [IW-1:0]    instr,
    output logic             instr_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_valid,
    output logic [WIDTH-1:0] acc_q,
    output logic             flag_z,
    output logic             flag_c
);

    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e               state_q, state_d;
    opcode_e              op_q, op_d;
    logic [RW-1:0]        idx_q, idx_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     acc_d;
    logic                 flag_z_d, flag_c_d;
    logic [WIDTH-1:0]     out_result_d;
    logic                 out_valid_d;
    logic [WIDTH-1:0]     regs_q [NREGS];

    logic                 hs;
    logic                 exec;
    logic                 exec_alu;
    logic                 rf_we;
    logic                 alu_bit;
    logic                 alu_cout;

    opcode_e              instr_op;
    logic                 instr_is_r;
    logic [RW-1:0]        instr_idx;
    logic [WIDTH-1:0]     instr_imm;
    logic [WIDTH-1:0]     rd_val;

    assign instr_op   = opcode_e'(instr[2:0]);
    assign instr_is_r = instr[R_TYPE_BIT];
    assign instr_imm  = instr[IW-1:OPC_W];
    assign instr_idx  = instr[OPC_W +: RW];

    // Indices at or beyond NREGS never match, so they read as zero.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (instr_idx == RW'(i)) begin
                rd_val = regs_q[i];
            end
        end
    end

    // FSM: state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (hs) state_d = S_EXEC;
            S_EXEC: if (!is_alu_op(op_q) || (cnt_q == CNT_LAST)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        instr_ready = (state_q == S_IDLE) && rst_n;
        hs          = instr_ready && instr_valid;
        exec        = (state_q == S_EXEC);
        exec_alu    = exec && is_alu_op(op_q);
        rf_we       = exec && (op_q == OP_STORE);
    end

    alu_bit_p u_alu (
        .clk      (clk),
        .rst_n    (rst_n),
        .preset_i (hs),
        .cin_i    (instr_op == OP_SUB),
        .en_i     (exec_alu),
        .op_i     (op_q),
        .a_i      (acc_q[0]),
        .b_i      (opnd_q[0]),
        .res_o    (alu_bit),
        .cout_o   (alu_cout)
    );

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        op_d         = op_q;
        idx_d        = idx_q;
        opnd_d       = opnd_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        flag_z_d     = flag_z;
        flag_c_d     = flag_c;
        out_result_d = out_result;
        out_valid_d  = 1'b0;

        if (hs) begin
            op_d   = instr_op;
            idx_d  = instr_idx;
            opnd_d = instr_is_r ? rd_val : instr_imm;
            cnt_d  = '0;
        end else if (exec) begin
            unique case (op_q)
                OP_LOAD: begin
                    acc_d    = opnd_q;
                    flag_z_d = (opnd_q == '0);
                end
                OP_STORE: ;
                OP_OUT: begin
                    out_result_d = acc_q;
                    out_valid_d  = 1'b1;
                end
                default: begin
                    acc_d  = {alu_bit, acc_q[WIDTH-1:1]};
                    opnd_d = opnd_q >> 1;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        flag_z_d = (acc_d == '0);
                        if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
                            flag_c_d = alu_cout;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q       <= OP_LOAD;
            idx_q      <= '0;
            opnd_q     <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
            out_result <= '0;
            out_valid  <= 1'b0;
        end else begin
            op_q       <= op_d;
            idx_q      <= idx_d;
            opnd_q     <= opnd_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            flag_z     <= flag_z_d;
            flag_c     <= flag_c_d;
            out_result <= out_result_d;
            out_valid  <= out_valid_d;
        end
    end

    // NOTE: the register file is architecturally cleared by reset, so it is
    // built from flops rather than a RAM macro that could not be reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (rf_we) begin
            for (int i = 0; i < NREGS; i++) begin
                if (idx_q == RW'(i)) begin
                    regs_q[i] <= acc_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_bitser_cpu_core.sv
// Directed bench for bitser_cpu_core: an 8-bit/4-register core and a
// 16-bit/3-register core driven through the valid/ready handshake.
module tb_bitser_cpu_core;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        v8;
    logic [11:0] i8;
    logic        rdy8, ov8, z8, c8;
    logic [7:0]  or8, acc8;

    logic        v16;
    logic [19:0] i16;
    logic        rdy16, ov16, z16, c16;
    logic [15:0] or16, acc16;

    int checks = 0;
    int errors = 0;
    int busy;

    always #5 clk = ~clk;

    bitser_cpu_core #(.WIDTH(8), .NREGS(4)) u_dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (v8),
        .instr       (i8),
        .instr_ready (rdy8),
        .out_result  (or8),
        .out_valid   (ov8),
        .acc_q       (acc8),
        .flag_z      (z8),
        .flag_c      (c8)
    );

    bitser_cpu_core #(.WIDTH(16), .NREGS(3)) u_dut16 (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (v16),
        .instr       (i16),
        .instr_ready (rdy16),
        .out_result  (or16),
        .out_valid   (ov16),
        .acc_q       (acc16),
        .flag_z      (z16),
        .flag_c      (c16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one instruction and returns the number of cycles instr_ready
    // stayed low after the handshake; ends on the cycle the core is idle again.
    task automatic run8(input logic [3:0] op, input logic [7:0] opd, output int nbusy);
        int n = 0;
        while (!rdy8 && n < 50) begin @(negedge clk); n++; end
        v8 = 1'b1;
        i8 = {opd, op};
        @(negedge clk);
        v8 = 1'b0;
        i8 = 12'hA5F;
        nbusy = 0;
        while (!rdy8 && nbusy < 50) begin @(negedge clk); nbusy++; end
        check("done8", 32'(nbusy < 50), 32'd1);
    endtask

    task automatic run16(input logic [3:0] op, input logic [15:0] opd, output int nbusy);
        int n = 0;
        while (!rdy16 && n < 50) begin @(negedge clk); n++; end
        v16 = 1'b1;
        i16 = {opd, op};
        @(negedge clk);
        v16 = 1'b0;
        i16 = 20'h5A5A7;
        nbusy = 0;
        while (!rdy16 && nbusy < 50) begin @(negedge clk); nbusy++; end
        check("done16", 32'(nbusy < 50), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        v8    = 1'b1;
        i8    = {8'hFF, 4'h0};
        v16   = 1'b0;
        i16   = '0;
        repeat (3) @(negedge clk);
        check("rst_ready",  32'(rdy8), 32'd0);
        check("rst_acc",    32'(acc8), 32'h00);
        check("rst_out",    32'(or8),  32'h00);
        check("rst_ovalid", 32'(ov8),  32'd0);
        check("rst_z",      32'(z8),   32'd0);
        check("rst_c",      32'(c8),   32'd0);
        rst_n = 1'b1;
        v8    = 1'b0;
        #1;
        check("post_rst_ready", 32'(rdy8), 32'd1);
        @(negedge clk);
        check("no_accept_in_rst", 32'(acc8), 32'h00);

        run8(4'h0, 8'h5A, busy);
        check("load_busy", busy, 32'd1);
        check("load_acc",  32'(acc8), 32'h5A);
        check("load_z",    32'(z8),   32'd0);
        run8(4'h7, 8'h00, busy);
        check("out_valid_hi", 32'(ov8), 32'd1);
        check("out_result",   32'(or8), 32'h5A);
        @(negedge clk);
        check("out_valid_lo", 32'(ov8), 32'd0);
        check("out_held",     32'(or8), 32'h5A);

        run8(4'h1, 8'hC8, busy);
        check("add_busy", busy, 32'd8);
        check("add_acc",  32'(acc8), 32'h22);
        check("add_c",    32'(c8),   32'd1);
        check("add_z",    32'(z8),   32'd0);

        run8(4'h6, 8'h02, busy);
        run8(4'h0, 8'h01, busy);
        run8(4'hA, 8'h02, busy);
        check("subr_acc", 32'(acc8), 32'hDF);
        check("subr_c",   32'(c8),   32'd0);

        run8(4'h0, 8'hDF, busy);
        run8(4'h2, 8'hDF, busy);
        check("sub_eq_acc", 32'(acc8), 32'h00);
        check("sub_eq_z",   32'(z8),   32'd1);
        check("sub_eq_c",   32'(c8),   32'd1);

        run8(4'h0, 8'h33, busy);
        run8(4'hD, 8'h05, busy);
        check("xor_r5_acc", 32'(acc8), 32'h33);
        check("xor_c_held", 32'(c8),   32'd1);
        run8(4'h6, 8'h05, busy);
        run8(4'hC, 8'h01, busy);
        check("or_r1_acc", 32'(acc8), 32'h33);

        run8(4'h0, 8'h00, busy);
        check("load0_z", 32'(z8), 32'd1);
        run8(4'h9, 8'h02, busy);
        check("add_r2_acc", 32'(acc8), 32'h22);
        check("add_r2_c",   32'(c8),   32'd0);

        run8(4'h0, 8'hF0, busy);
        run8(4'h3, 8'h3C, busy);
        check("and_acc", 32'(acc8), 32'h30);

        run8(4'h0, 8'hFF, busy);
        run8(4'h1, 8'h01, busy);
        check("wrap_acc", 32'(acc8), 32'h00);
        check("wrap_z",   32'(z8),   32'd1);
        check("wrap_c",   32'(c8),   32'd1);

        // Abort an ADD with reset on its fourth EXEC cycle.
        run8(4'h0, 8'h5A, busy);
        run8(4'h7, 8'h00, busy);
        @(negedge clk);
        v8 = 1'b1;
        i8 = {8'hC8, 4'h1};
        @(negedge clk);
        v8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_acc",    32'(acc8), 32'h00);
        check("abort_z",      32'(z8),   32'd0);
        check("abort_c",      32'(c8),   32'd0);
        check("abort_ovalid", 32'(ov8),  32'd0);
        check("abort_out",    32'(or8),  32'h00);
        check("abort_ready",  32'(rdy8), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run16(4'h0, 16'hFFFF, busy);
        run16(4'h1, 16'h0001, busy);
        check("w16_busy", busy, 32'd16);
        check("w16_acc",  32'(acc16), 32'h0000);
        check("w16_z",    32'(z16),   32'd1);
        check("w16_c",    32'(c16),   32'd1);

        run16(4'h0, 16'h1234, busy);
        run16(4'h6, 16'h0003, busy);
        run16(4'h6, 16'h0002, busy);
        run16(4'h0, 16'h0001, busy);
        run16(4'hC, 16'h0003, busy);
        check("w16_oob_acc", 32'(acc16), 32'h0001);
        run16(4'h9, 16'h0002, busy);
        check("w16_addr_acc", 32'(acc16), 32'h1235);
        check("w16_addr_c",   32'(c16),   32'd0);
        check("w16_addr_z",   32'(z16),   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
